// File: rtl/fsm_io_pkg.sv
// Shared widths, defaults and simulation-friendly timing for the FSM input stage.
package fsm_io_pkg;

    localparam int SW_W_DEF        = 2;
    localparam int STEP_CNT_W      = 8;
    localparam int DB_CYCLES_DEF   = 50000;
    localparam int AUTO_PERIOD_DEF = 25000000;

    // Short timings so a simulation sees debounce and auto-step in a few cycles.
    localparam int DB_CYCLES_SIM   = 4;
    localparam int AUTO_PERIOD_SIM = 8;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } run_mode_e;

    // Counter width able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fsm_step_ctrl_debounce_bit.sv
// One raw input bit: 2-flop synchronizer followed by a stable-count debouncer.
// hold_i stalls a completing update by one edge so the consumer never sees
// this bit change on the same edge as a step strobe.
module debounce_bit
    import fsm_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_SIM
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    input  logic hold_i,
    output logic stable_o
);

    localparam int CW = cnt_w(DB_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic          done;

    // True when this edge would bring the count up to DB_CYCLES (or it is parked there).
    assign done = ({1'b0, cnt_q} + 1'b1) >= (CW+1)'(DB_CYCLES);

    // Synchronize, count consecutive disagreeing cycles, adopt the new level when the count completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (done) begin
                if (hold_i) begin
                    cnt_q <= CW'(DB_CYCLES);
                end else begin
                    stable_q <= sync2_q;
                    cnt_q    <= '0;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/fsm_step_ctrl.sv
// Conditions switches, step button and run-mode switch for the Mealy FSM demos:
// clean input vector plus a one-cycle advance strobe from button or auto timer.
module fsm_step_ctrl
    import fsm_io_pkg::*;
#(
    parameter int SW_W        = SW_W_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF,
    parameter int AUTO_PERIOD = AUTO_PERIOD_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SW_W-1:0]       sw_raw,
    input  logic                  step_btn_raw,
    input  logic                  run_mode_raw,
    output logic [SW_W-1:0]       sw_out,
    output logic                  step_pulse,
    output logic                  auto_active,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int TW = $clog2(AUTO_PERIOD);

    logic                  btn_stable;
    logic                  btn_prev_q;
    logic [TW-1:0]         timer_q;
    logic                  step_pulse_q;
    logic                  step_pulse_d;
    logic [STEP_CNT_W-1:0] step_count_q;
    logic                  sw_hold;
    run_mode_e             mode;

    // Switch bits freeze for one edge whenever the strobe is about to rise.
    assign sw_hold = step_pulse_d & ~step_pulse_q;

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_sw (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (sw_raw[i]),
            .hold_i   (sw_hold),
            .stable_o (sw_out[i])
        );
    end

    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_btn (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (step_btn_raw),
        .hold_i   (1'b0),
        .stable_o (btn_stable)
    );

    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_mode (
        .clk      (clk),
        .reset    (reset),
        .raw_i    (run_mode_raw),
        .hold_i   (1'b0),
        .stable_o (auto_active)
    );

    assign mode = run_mode_e'(auto_active);

    // Strobe source: timer wrap in auto mode, debounced button rise in manual mode.
    // Mode is the registered debounced value, so an edge coinciding with a mode
    // change is judged under the new mode.
    always_comb begin
        step_pulse_d = 1'b0;
        case (mode)
            MODE_AUTO:   step_pulse_d = (timer_q == TW'(AUTO_PERIOD - 1));
            default:     step_pulse_d = btn_stable & ~btn_prev_q;
        endcase
    end

    // Edge register, auto timer (held at zero outside auto), strobe and wrap-around step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev_q   <= 1'b0;
            timer_q      <= '0;
            step_pulse_q <= 1'b0;
            step_count_q <= '0;
        end else begin
            btn_prev_q   <= btn_stable;
            step_pulse_q <= step_pulse_d;
            step_count_q <= step_count_q + STEP_CNT_W'(step_pulse_q);
            if (mode != MODE_AUTO || timer_q == TW'(AUTO_PERIOD - 1))
                timer_q <= '0;
            else
                timer_q <= timer_q + 1'b1;
        end
    end

    assign step_pulse = step_pulse_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Bench for fsm_step_ctrl at simulation timings (DB_CYCLES=4, AUTO_PERIOD=8).
module tb_fsm_step_ctrl;
    import fsm_io_pkg::*;

    localparam int SW = 2;
    localparam int DB = DB_CYCLES_SIM;
    localparam int AP = AUTO_PERIOD_SIM;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [SW-1:0]         sw_raw;
    logic                  step_btn_raw;
    logic                  run_mode_raw;
    logic [SW-1:0]         sw_out;
    logic                  step_pulse;
    logic                  auto_active;
    logic [STEP_CNT_W-1:0] step_count;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int exp_q[$];          // cycle numbers at which step_pulse must be seen high

    typedef struct {
        logic [SW-1:0] sw;
        int            dwell;
        logic [SW-1:0] exp_sw;
    } vec_t;
    vec_t vecs[11];

    fsm_step_ctrl #(.SW_W(SW), .DB_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_raw       (sw_raw),
        .step_btn_raw (step_btn_raw),
        .run_mode_raw (run_mode_raw),
        .sw_out       (sw_out),
        .step_pulse   (step_pulse),
        .auto_active  (auto_active),
        .step_count   (step_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and score step_pulse against the queue.
    task automatic tick();
        @(posedge clk);
        #1;
        if (step_pulse !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: step_pulse=%b, expected 0", cyc, step_pulse);
            end else begin
                chk("pulse_cycle", cyc, exp_q.pop_front());
            end
        end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse at cycle %0d: step_pulse=0, expected 1 at cycle %0d", cyc, exp_q[0]);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e, x, m, p;

        // Switch vectors in manual mode: bounces, a DB-1 glitch, exact latency boundaries.
        vecs[0]  = '{2'b01, 2, 2'b00};
        vecs[1]  = '{2'b00, 2, 2'b00};
        vecs[2]  = '{2'b01, 2, 2'b00};
        vecs[3]  = '{2'b01, 3, 2'b00};   // 5 edges into the final hold: still old
        vecs[4]  = '{2'b01, 1, 2'b01};   // 6th edge: new value
        vecs[5]  = '{2'b11, 5, 2'b01};
        vecs[6]  = '{2'b11, 1, 2'b11};
        vecs[7]  = '{2'b10, 3, 2'b11};   // 3-cycle glitch on bit 0
        vecs[8]  = '{2'b11, 3, 2'b11};
        vecs[9]  = '{2'b00, 5, 2'b11};
        vecs[10] = '{2'b00, 1, 2'b00};

        reset = 1'b1; sw_raw = '0; step_btn_raw = 1'b0; run_mode_raw = 1'b0;
        run(2);
        chk("reset_sw_out", sw_out, 0);
        chk("reset_pulse", step_pulse, 0);
        chk("reset_auto", auto_active, 0);
        chk("reset_count", step_count, 0);
        reset = 1'b0;
        run(3);

        // Manual press: one pulse 7 edges after first sampling, nothing while held or on release.
        n = cyc;
        step_btn_raw = 1'b1;
        exp_q.push_back(n + DB + 3);
        wait_to(n + DB + 4);
        chk("press_count", step_count, 1);
        run(20);
        step_btn_raw = 1'b0;
        run(20);
        chk("press_count_after_release", step_count, 1);

        for (int i = 0; i < 11; i++) begin
            sw_raw = vecs[i].sw;
            run(vecs[i].dwell);
            chk($sformatf("sw_vec%0d", i), sw_out, vecs[i].exp_sw);
        end

        // Auto mode: pulses every AP cycles starting AP after auto_active rises.
        n = cyc;
        run_mode_raw = 1'b1;
        wait_to(n + DB + 1);
        chk("auto_not_yet", auto_active, 0);
        tick();
        chk("auto_rise", auto_active, 1);
        e = cyc;
        for (int k = 1; k <= 257; k++) exp_q.push_back(e + k * AP);
        wait_to(n + 10);
        step_btn_raw = 1'b1;                // ignored in auto mode
        wait_to(n + 30);
        step_btn_raw = 1'b0;
        wait_to(e + 5 * AP + 1);
        chk("auto_count5", step_count, 6);

        // Collision: switch debounce completes on the same edge as auto pulse #10.
        x = e + 10 * AP;
        wait_to(x - DB - 2);
        sw_raw = 2'b01;
        wait_to(x - 1);
        chk("coll_before", sw_out, 2'b00);
        tick();
        chk("coll_pulse", step_pulse, 1);
        chk("coll_sw_old", sw_out, 2'b00);
        tick();
        chk("coll_sw_new", sw_out, 2'b01);

        // Wrap: 1 manual + 255 auto pulses bring the count back to 0.
        wait_to(e + 255 * AP);
        chk("wrap_255", step_count, 255);
        tick();
        chk("wrap_0", step_count, 0);
        wait_to(e + 256 * AP + 1);
        chk("wrap_1", step_count, 1);

        // Leave auto mode mid-count: auto_active falls 4 cycles into a period.
        m = e + 257 * AP - 2;
        wait_to(m);
        run_mode_raw = 1'b0;
        wait_to(m + DB + 1);
        chk("auto_still_on", auto_active, 1);
        tick();
        chk("auto_fall", auto_active, 0);
        run(30);
        chk("leave_count", step_count, 2);
        chk("leave_queue_empty", exp_q.size(), 0);

        // Reset while the button debounce counter sits at 3.
        sw_raw = 2'b00;
        run(10);
        chk("pre_reset_sw", sw_out, 2'b00);
        n = cyc;
        step_btn_raw = 1'b1;
        wait_to(n + DB + 1);
        reset = 1'b1;
        step_btn_raw = 1'b0;
        run(2);
        chk("midreset_count", step_count, 0);
        chk("midreset_pulse", step_pulse, 0);
        reset = 1'b0;
        run(20);
        chk("post_reset_sw", sw_out, 0);
        chk("post_reset_auto", auto_active, 0);
        chk("post_reset_count", step_count, 0);

        // Fresh press after reset needs the full latency.
        p = cyc;
        step_btn_raw = 1'b1;
        exp_q.push_back(p + DB + 3);
        wait_to(p + DB + 2);
        chk("fresh_not_yet", step_pulse, 0);
        tick();
        chk("fresh_pulse", step_pulse, 1);
        tick();
        chk("fresh_count", step_count, 1);
        step_btn_raw = 1'b0;
        run(15);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
